// File: rtl/axi_lite_arb2_if.sv
// rtl/axi_lite_arb2_if.sv - AXI-lite bundle (AR, R, AW, W, B) shared by requesters and slave
// master modport: drives ar/aw/w valid+payload, r_ready, b_ready
// slave modport : drives ar/aw/w ready, r valid+data+resp, b valid+resp
interface axi_lite_arb2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ar_valid;
    logic [ADDR_W-1:0]     ar_addr;
    logic                  ar_ready;
    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic [1:0]            r_resp;
    logic                  r_ready;
    logic                  aw_valid;
    logic [ADDR_W-1:0]     aw_addr;
    logic                  aw_ready;
    logic                  w_valid;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;
    logic                  w_ready;
    logic                  b_valid;
    logic [1:0]            b_resp;
    logic                  b_ready;

    modport master (
        output ar_valid, ar_addr, input  ar_ready,
        input  r_valid, r_data, r_resp, output r_ready,
        output aw_valid, aw_addr, input  aw_ready,
        output w_valid, w_data, w_strb, input  w_ready,
        input  b_valid, b_resp, output b_ready
    );

    modport slave (
        input  ar_valid, ar_addr, output ar_ready,
        output r_valid, r_data, r_resp, input  r_ready,
        input  aw_valid, aw_addr, output aw_ready,
        input  w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input  b_ready
    );
endinterface

// File: rtl/axi_lite_arb2.sv
// rtl/axi_lite_arb2.sv - two-requester AXI-lite transaction arbiter (round-robin, whole transactions)
// clk_i   : clock
// rst_n_i : asynchronous active-low reset
// in0     : requester 0 (IFU) bundle, slave side
// in1     : requester 1 (LSU) bundle, slave side
// out     : bundle to the memory slave, master side
// gnt_o   : one-hot current owner, 0 when idle
// busy_o  : transaction in progress
module axi_lite_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    axi_lite_arb2_if.slave        in0,
    axi_lite_arb2_if.slave        in1,
    axi_lite_arb2_if.master       out,
    output logic [1:0]            gnt_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_RESP = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last_gnt, last_gnt_nxt;
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;

    // owner-selected requester signals
    logic                  own_ar_valid;
    logic [ADDR_W-1:0]     own_ar_addr;
    logic                  own_r_ready;
    logic                  own_aw_valid;
    logic [ADDR_W-1:0]     own_aw_addr;
    logic                  own_w_valid;
    logic [DATA_W-1:0]     own_w_data;
    logic [DATA_W/8-1:0]   own_w_strb;
    logic                  own_b_ready;

    assign own_ar_valid = owner ? in1.ar_valid : in0.ar_valid;
    assign own_ar_addr  = owner ? in1.ar_addr  : in0.ar_addr;
    assign own_r_ready  = owner ? in1.r_ready  : in0.r_ready;
    assign own_aw_valid = owner ? in1.aw_valid : in0.aw_valid;
    assign own_aw_addr  = owner ? in1.aw_addr  : in0.aw_addr;
    assign own_w_valid  = owner ? in1.w_valid  : in0.w_valid;
    assign own_w_data   = owner ? in1.w_data   : in0.w_data;
    assign own_w_strb   = owner ? in1.w_strb   : in0.w_strb;
    assign own_b_ready  = owner ? in1.b_ready  : in0.b_ready;

    logic st_rd_addr, st_rd_resp, st_wr_req, st_wr_resp;
    assign st_rd_addr = (state == RD_ADDR);
    assign st_rd_resp = (state == RD_RESP);
    assign st_wr_req  = (state == WR_REQ);
    assign st_wr_resp = (state == WR_RESP);

    // slave-facing side: valids only in the matching phase, AW/W suppressed once accepted
    assign out.ar_valid = st_rd_addr & own_ar_valid;
    assign out.ar_addr  = own_ar_addr;
    assign out.r_ready  = st_rd_resp & own_r_ready;
    assign out.aw_valid = st_wr_req & ~aw_done & own_aw_valid;
    assign out.aw_addr  = own_aw_addr;
    assign out.w_valid  = st_wr_req & ~w_done & own_w_valid;
    assign out.w_data   = own_w_data;
    assign out.w_strb   = own_w_strb;
    assign out.b_ready  = st_wr_resp & own_b_ready;

    // requester-facing side: only the owner ever sees a ready or valid
    assign in0.ar_ready = ~owner & st_rd_addr & out.ar_ready;
    assign in0.r_valid  = ~owner & st_rd_resp & out.r_valid;
    assign in0.aw_ready = ~owner & st_wr_req & ~aw_done & out.aw_ready;
    assign in0.w_ready  = ~owner & st_wr_req & ~w_done & out.w_ready;
    assign in0.b_valid  = ~owner & st_wr_resp & out.b_valid;
    assign in0.r_data   = out.r_data;
    assign in0.r_resp   = out.r_resp;
    assign in0.b_resp   = out.b_resp;

    assign in1.ar_ready = owner & st_rd_addr & out.ar_ready;
    assign in1.r_valid  = owner & st_rd_resp & out.r_valid;
    assign in1.aw_ready = owner & st_wr_req & ~aw_done & out.aw_ready;
    assign in1.w_ready  = owner & st_wr_req & ~w_done & out.w_ready;
    assign in1.b_valid  = owner & st_wr_resp & out.b_valid;
    assign in1.r_data   = out.r_data;
    assign in1.r_resp   = out.r_resp;
    assign in1.b_resp   = out.b_resp;

    // arbitration: a lone requester wins, a tie goes to the one not served last
    logic req0, req1, pick, pick_ar;
    assign req0    = in0.ar_valid | in0.aw_valid;
    assign req1    = in1.ar_valid | in1.aw_valid;
    assign pick    = (req0 & req1) ? ~last_gnt : req1;
    assign pick_ar = pick ? in1.ar_valid : in0.ar_valid;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;
    assign ar_hs  = out.ar_valid & out.ar_ready;
    assign r_hs   = out.r_valid & out.r_ready;
    assign aw_hs  = out.aw_valid & out.aw_ready;
    assign w_hs   = out.w_valid & out.w_ready;
    assign b_hs   = out.b_valid & out.b_ready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        aw_done_nxt  = aw_done;
        w_done_nxt   = w_done;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    owner_nxt = pick;
                    state_nxt = pick_ar ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                if (ar_hs) state_nxt = RD_RESP;
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = owner;
                end
            end
            WR_REQ: begin
                if (aw_fin && w_fin) begin
                    state_nxt   = WR_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_fin;
                    w_done_nxt  = w_fin;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
            aw_done  <= aw_done_nxt;
            w_done   <= w_done_nxt;
        end
    end

    assign busy_o = (state != IDLE);
    assign gnt_o  = {busy_o & owner, busy_o & ~owner};

endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb/tb_axi_lite_arb2.sv - self-checking bench for axi_lite_arb2
module tb_axi_lite_arb2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_arb2_if #(.ADDR_W(32), .DATA_W(32)) in0_if ();
    axi_lite_arb2_if #(.ADDR_W(32), .DATA_W(32)) in1_if ();
    axi_lite_arb2_if #(.ADDR_W(32), .DATA_W(32)) out_if ();
    logic [1:0] gnt_o;
    logic       busy_o;

    axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .in0(in0_if), .in1(in1_if), .out(out_if),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // requester drive arrays
    logic        rq_ar_valid[2];
    logic [31:0] rq_ar_addr[2];
    logic        rq_r_ready[2];
    logic        rq_aw_valid[2];
    logic [31:0] rq_aw_addr[2];
    logic        rq_w_valid[2];
    logic [31:0] rq_w_data[2];
    logic [3:0]  rq_w_strb[2];
    logic        rq_b_ready[2];

    assign in0_if.ar_valid = rq_ar_valid[0]; assign in1_if.ar_valid = rq_ar_valid[1];
    assign in0_if.ar_addr  = rq_ar_addr[0];  assign in1_if.ar_addr  = rq_ar_addr[1];
    assign in0_if.r_ready  = rq_r_ready[0];  assign in1_if.r_ready  = rq_r_ready[1];
    assign in0_if.aw_valid = rq_aw_valid[0]; assign in1_if.aw_valid = rq_aw_valid[1];
    assign in0_if.aw_addr  = rq_aw_addr[0];  assign in1_if.aw_addr  = rq_aw_addr[1];
    assign in0_if.w_valid  = rq_w_valid[0];  assign in1_if.w_valid  = rq_w_valid[1];
    assign in0_if.w_data   = rq_w_data[0];   assign in1_if.w_data   = rq_w_data[1];
    assign in0_if.w_strb   = rq_w_strb[0];   assign in1_if.w_strb   = rq_w_strb[1];
    assign in0_if.b_ready  = rq_b_ready[0];  assign in1_if.b_ready  = rq_b_ready[1];

    logic        d_ar_ready[2], d_r_valid[2], d_aw_ready[2], d_w_ready[2], d_b_valid[2];
    logic [31:0] d_r_data[2];
    logic [1:0]  d_r_resp[2];
    assign d_ar_ready[0] = in0_if.ar_ready; assign d_ar_ready[1] = in1_if.ar_ready;
    assign d_r_valid[0]  = in0_if.r_valid;  assign d_r_valid[1]  = in1_if.r_valid;
    assign d_aw_ready[0] = in0_if.aw_ready; assign d_aw_ready[1] = in1_if.aw_ready;
    assign d_w_ready[0]  = in0_if.w_ready;  assign d_w_ready[1]  = in1_if.w_ready;
    assign d_b_valid[0]  = in0_if.b_valid;  assign d_b_valid[1]  = in1_if.b_valid;
    assign d_r_data[0]   = in0_if.r_data;   assign d_r_data[1]   = in1_if.r_data;
    assign d_r_resp[0]   = in0_if.r_resp;   assign d_r_resp[1]   = in1_if.r_resp;

    logic [17:0] act_ctl;
    assign act_ctl = {gnt_o, busy_o,
                      out_if.ar_valid, out_if.aw_valid, out_if.w_valid, out_if.r_ready, out_if.b_ready,
                      in0_if.ar_ready, in0_if.r_valid, in0_if.aw_ready, in0_if.w_ready, in0_if.b_valid,
                      in1_if.ar_ready, in1_if.r_valid, in1_if.aw_ready, in1_if.w_ready, in1_if.b_valid};

    // memory slave model
    logic        slv_aw_rdy = 1'b1;
    logic [31:0] slv_rdata = 32'h0;
    logic [31:0] slv_awaddr, slv_wdata;
    logic [3:0]  slv_wstrb;
    int          cnt_ar = 0, cnt_aw = 0, cnt_w = 0;
    assign out_if.aw_ready = slv_aw_rdy;

    initial begin
        bit s_ar, s_r, s_aw, s_w, s_b, got_aw, got_w;
        got_aw = 0; got_w = 0;
        out_if.ar_ready = 1'b1; out_if.w_ready = 1'b1;
        out_if.r_valid = 1'b0; out_if.r_data = '0; out_if.r_resp = 2'd0;
        out_if.b_valid = 1'b0; out_if.b_resp = 2'd0;
        forever begin
            @(negedge clk);
            s_ar = out_if.ar_valid & out_if.ar_ready;
            s_r  = out_if.r_valid & out_if.r_ready;
            s_aw = out_if.aw_valid & out_if.aw_ready;
            s_w  = out_if.w_valid & out_if.w_ready;
            s_b  = out_if.b_valid & out_if.b_ready;
            if (s_ar) cnt_ar++;
            if (s_aw) begin cnt_aw++; slv_awaddr = out_if.aw_addr; end
            if (s_w)  begin cnt_w++; slv_wdata = out_if.w_data; slv_wstrb = out_if.w_strb; end
            @(posedge clk); #1;
            if (!rst_n) begin
                out_if.r_valid = 1'b0; out_if.b_valid = 1'b0; got_aw = 0; got_w = 0;
            end else begin
                if (s_r) out_if.r_valid = 1'b0;
                if (s_ar) begin out_if.r_valid = 1'b1; out_if.r_data = slv_rdata; out_if.r_resp = 2'd0; end
                if (s_aw) got_aw = 1;
                if (s_w)  got_w = 1;
                if (s_b)  out_if.b_valid = 1'b0;
                if (got_aw && got_w) begin out_if.b_valid = 1'b1; out_if.b_resp = 2'd0; got_aw = 0; got_w = 0; end
            end
        end
    end

    // transaction-level reference: who owns the slave, what kind, which halves are done
    int  m_owner = -1;
    bit  m_last = 1'b1, m_rd, m_a, m_d, m_b;
    int  glog[$];
    bit  klog[$];

    always @(negedge clk) begin
        logic [17:0] e;
        logic [4:0]  eo;
        int o, pk;
        bit r0, r1;
        if (!rst_n) begin m_owner = -1; m_last = 1'b1; end
        o = m_owner;
        e = '0; eo = '0;
        if (o >= 0) begin
            e[17:16] = (o == 1) ? 2'b10 : 2'b01;
            e[15] = 1'b1;
            if (m_rd && !m_a) begin e[14] = rq_ar_valid[o]; eo[4] = out_if.ar_ready; end
            if (m_rd && m_a)  begin e[11] = rq_r_ready[o];  eo[3] = out_if.r_valid; end
            if (!m_rd && !m_b) begin
                e[13] = !m_a && rq_aw_valid[o]; eo[2] = !m_a && out_if.aw_ready;
                e[12] = !m_d && rq_w_valid[o];  eo[1] = !m_d && out_if.w_ready;
            end
            if (!m_rd && m_b) begin e[10] = rq_b_ready[o]; eo[0] = out_if.b_valid; end
            if (o == 0) e[9:5] = eo; else e[4:0] = eo;
        end
        chk("ctl", 32'(act_ctl), 32'(e));
        if (e[14]) chk("ar_addr", out_if.ar_addr, rq_ar_addr[o]);
        if (e[13]) chk("aw_addr", out_if.aw_addr, rq_aw_addr[o]);
        if (e[12]) chk("w_data", out_if.w_data, rq_w_data[o]);
        if (e[12]) chk("w_strb", 32'(out_if.w_strb), 32'(rq_w_strb[o]));
        if (e[8] | e[3]) chk("r_data", d_r_data[o], out_if.r_data);
        if (rst_n) begin
            if (m_owner < 0) begin
                r0 = rq_ar_valid[0] | rq_aw_valid[0];
                r1 = rq_ar_valid[1] | rq_aw_valid[1];
                if (r0 | r1) begin
                    pk = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
                    m_owner = pk; m_rd = rq_ar_valid[pk]; m_a = 0; m_d = 0; m_b = 0;
                    glog.push_back(pk); klog.push_back(m_rd);
                end
            end else if (m_rd) begin
                if (!m_a) begin
                    if (rq_ar_valid[o] && out_if.ar_ready) m_a = 1;
                end else if (rq_r_ready[o] && out_if.r_valid) begin
                    m_last = (o == 1); m_owner = -1;
                end
            end else if (!m_b) begin
                if (rq_aw_valid[o] && out_if.aw_ready) m_a = 1;
                if (rq_w_valid[o] && out_if.w_ready) m_d = 1;
                if (m_a && m_d) m_b = 1;
            end else if (rq_b_ready[o] && out_if.b_valid) begin
                m_last = (o == 1); m_owner = -1;
            end
        end
    end

    task automatic rd(input int n, input logic [31:0] addr, output logic [31:0] data);
        bit ok;
        rq_ar_valid[n] = 1'b1; rq_ar_addr[n] = addr;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d_ar_ready[n]) begin ok = 1; break; end
        end
        chk("ar_wait", 32'(ok), 32'd1);
        @(posedge clk); #1;
        rq_ar_valid[n] = 1'b0;
        ok = 0; data = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d_r_valid[n] && rq_r_ready[n]) begin ok = 1; data = d_r_data[n]; break; end
        end
        chk("r_wait", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wr(input int n, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int wdly);
        bit oka, okw, okb;
        fork
            begin
                rq_aw_valid[n] = 1'b1; rq_aw_addr[n] = addr; oka = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (d_aw_ready[n]) begin oka = 1; break; end
                end
                @(posedge clk); #1;
                rq_aw_valid[n] = 1'b0;
            end
            begin
                repeat (wdly) @(posedge clk);
                #1;
                rq_w_valid[n] = 1'b1; rq_w_data[n] = data; rq_w_strb[n] = strb; okw = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (d_w_ready[n]) begin okw = 1; break; end
                end
                @(posedge clk); #1;
                rq_w_valid[n] = 1'b0;
            end
        join
        chk("aw_wait", 32'(oka), 32'd1);
        chk("w_wait", 32'(okw), 32'd1);
        okb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d_b_valid[n]) begin okb = 1; break; end
        end
        chk("b_wait", 32'(okb), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d0, d1;
        int c_aw, c_w;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            rq_ar_valid[i] = 0; rq_ar_addr[i] = '0; rq_r_ready[i] = 1;
            rq_aw_valid[i] = 0; rq_aw_addr[i] = '0; rq_w_valid[i] = 0;
            rq_w_data[i] = '0; rq_w_strb[i] = '0; rq_b_ready[i] = 1;
        end
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'(act_ctl), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // simultaneous requests right after reset: in0 first, then in1
        glog.delete();
        fork
            rd(0, 32'h8000_0000, d0);
            rd(1, 32'h8000_0040, d1);
        join
        chk("tie_n", glog.size(), 2);
        chk("tie_g0", glog[0], 0);
        chk("tie_g1", glog[1], 1);

        // continuous reads from both: strict alternation
        glog.delete();
        fork
            begin rd(0, 32'h8000_0010, d0); rd(0, 32'h8000_0014, d0); end
            begin rd(1, 32'h8000_0050, d1); rd(1, 32'h8000_0054, d1); end
        join
        chk("rr_n", glog.size(), 4);
        chk("rr_g0", glog[0], 0);
        chk("rr_g1", glog[1], 1);
        chk("rr_g2", glog[2], 0);
        chk("rr_g3", glog[3], 1);

        // single in0 read: latency, grant and forwarded data
        slv_rdata = 32'hDEAD_BEEF;
        rq_ar_valid[0] = 1'b1; rq_ar_addr[0] = 32'h8000_0000;
        @(negedge clk);
        chk("lat_same_cycle", 32'(out_if.ar_valid), 32'd0);
        @(negedge clk);
        chk("lat_next_cycle", 32'(out_if.ar_valid), 32'd1);
        chk("rd_gnt", 32'(gnt_o), 32'd1);
        chk("rd_addr", out_if.ar_addr, 32'h8000_0000);
        @(posedge clk); #1;
        rq_ar_valid[0] = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d_r_valid[0]) begin ok = 1; d0 = d_r_data[0]; break; end
        end
        chk("rd_rvalid", 32'(ok), 32'd1);
        chk("rd_data", d0, 32'hDEAD_BEEF);
        chk("rd_resp", 32'(d_r_resp[0]), 32'd0);
        chk("rd_gnt_resp", 32'(gnt_o), 32'd1);
        @(posedge clk); #1;

        // in1 write, W three cycles behind AW
        c_aw = cnt_aw; c_w = cnt_w;
        wr(1, 32'h8000_0100, 32'h1234_5678, 4'hF, 3);
        chk("wr1_aw_cnt", cnt_aw - c_aw, 1);
        chk("wr1_w_cnt", cnt_w - c_w, 1);
        chk("wr1_addr", slv_awaddr, 32'h8000_0100);
        chk("wr1_data", slv_wdata, 32'h1234_5678);
        chk("wr1_strb", 32'(slv_wstrb), 32'hF);

        // in1 write, W ready immediately, slave holds off AW
        c_aw = cnt_aw; c_w = cnt_w;
        slv_aw_rdy = 1'b0;
        fork
            wr(1, 32'h8000_0100, 32'h1234_5678, 4'hF, 0);
            begin repeat (4) @(posedge clk); #1; slv_aw_rdy = 1'b1; end
        join
        chk("wr2_aw_cnt", cnt_aw - c_aw, 1);
        chk("wr2_w_cnt", cnt_w - c_w, 1);
        chk("wr2_data", slv_wdata, 32'h1234_5678);

        // in0 read and write together: read first, write next
        glog.delete(); klog.delete();
        fork
            rd(0, 32'h8000_0200, d0);
            wr(0, 32'h8000_0204, 32'hCAFE_0001, 4'h3, 0);
        join
        chk("rw_n", glog.size(), 2);
        chk("rw_g0", glog[0], 0);
        chk("rw_g1", glog[1], 0);
        chk("rw_k0", 32'(klog[0]), 32'd1);
        chk("rw_k1", 32'(klog[1]), 32'd0);
        chk("rw_strb", 32'(slv_wstrb), 32'h3);

        // asynchronous reset while in RD_RESP
        rq_r_ready[0] = 1'b0;
        rq_ar_valid[0] = 1'b1; rq_ar_addr[0] = 32'h8000_0300;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d_ar_ready[0]) begin ok = 1; break; end
        end
        chk("rst_ar", 32'(ok), 32'd1);
        @(posedge clk); #1;
        rq_ar_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy_o), 32'd1);
        chk("rst_pre_slv_rvalid", 32'(out_if.r_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 32'(act_ctl), 32'd0);
        rq_r_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        glog.delete();
        fork
            rd(0, 32'h8000_0000, d0);
            rd(1, 32'h8000_0040, d1);
        join
        chk("rst_tie_n", glog.size(), 2);
        chk("rst_tie_g0", glog[0], 0);
        chk("rst_tie_g1", glog[1], 1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
